// File: rtl/pe_layer_sequencer.sv
// Job-level controller for one neural_network_pe: clear, load weights, stream
// activations, collect the final PE result and hand it to the host.
module pe_layer_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int LEN_W         = 5,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        vec_len,
  input  logic [1:0]              act_func,
  input  logic [1:0]              df_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    pe_enable,
  output logic                    pe_load_weight,
  output logic                    pe_clear_acc,
  output logic                    pe_forward_output,
  output logic [1:0]              pe_act_func_sel,
  output logic [1:0]              pe_dataflow_mode,
  output logic [WEIGHT_WIDTH-1:0] pe_weight,
  output logic [DATA_WIDTH-1:0]   pe_activation,
  output logic                    pe_upstream_valid,
  input  logic                    pe_upstream_ready,
  input  logic                    pe_downstream_valid,
  output logic                    pe_downstream_ready,
  input  logic [DATA_WIDTH-1:0]   pe_result
);

  localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [TW-1:0]    TMO_ONE  = TW'(1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, STREAM, DRAIN, OUTPUT, DONE} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len, w_cnt, a_cnt, r_cnt, r_cnt_nxt;
  logic [TW-1:0]           tmo;
  logic                    err_q, load_q;
  logic [1:0]              af_q, df_q;
  logic [WEIGHT_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic                    collect, a_hs, r_hit;

  assign collect   = (state == STREAM) || (state == DRAIN);
  assign a_hs      = (state == STREAM) && a_valid && pe_upstream_ready;
  assign r_hit     = collect && pe_downstream_valid;
  // Count including a result landing this cycle, so DRAIN exits without a dead cycle.
  assign r_cnt_nxt = r_hit ? r_cnt + CNT_ONE : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      len    <= '0;
      w_cnt  <= '0;
      a_cnt  <= '0;
      r_cnt  <= '0;
      tmo    <= '0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      af_q   <= '0;
      df_q   <= '0;
      w_q    <= '0;
      res_q  <= '0;
    end else begin
      load_q <= 1'b0;
      if (r_hit) begin
        res_q <= pe_result;
        r_cnt <= r_cnt_nxt;
      end
      if (abort && state != IDLE && state != DONE) begin
        err_q <= 1'b0;
        state <= DONE;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (vec_len == '0) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              len   <= vec_len;
              af_q  <= act_func;
              df_q  <= df_mode;
              state <= CLEAR;
            end
          end
          CLEAR: begin
            w_cnt <= '0;
            a_cnt <= '0;
            r_cnt <= '0;
            state <= LOAD_W;
          end
          LOAD_W: if (w_valid) begin
            w_q    <= w_data;
            load_q <= 1'b1;
            w_cnt  <= w_cnt + CNT_ONE;
            if (w_cnt + CNT_ONE == len) state <= STREAM;
          end
          STREAM: if (a_hs) begin
            a_cnt <= a_cnt + CNT_ONE;
            if (a_cnt + CNT_ONE == len) begin
              tmo   <= '0;
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (r_cnt_nxt == len) state <= OUTPUT;
            else if (r_hit) tmo <= '0;
            else if (tmo == TMO_LAST) begin
              err_q <= 1'b1;
              state <= DONE;
            end else tmo <= tmo + TMO_ONE;
          end
          OUTPUT: if (r_ready) begin
            err_q <= 1'b0;
            state <= DONE;
          end
          DONE: begin
            err_q <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy                = (state != IDLE);
  assign done                = (state == DONE);
  assign err                 = (state == DONE) && err_q;
  assign w_ready             = (state == LOAD_W);
  assign a_ready             = (state == STREAM) && pe_upstream_ready;
  assign r_valid             = (state == OUTPUT);
  assign r_data              = res_q;
  assign pe_enable           = (state != IDLE) && (state != DONE);
  assign pe_load_weight      = load_q;
  assign pe_clear_acc        = (state == CLEAR);
  assign pe_forward_output   = collect;
  assign pe_downstream_ready = collect;
  assign pe_act_func_sel     = af_q;
  assign pe_dataflow_mode    = df_q;
  assign pe_weight           = w_q;
  assign pe_activation       = a_data;
  assign pe_upstream_valid   = (state == STREAM) && a_valid;

endmodule
